// File: rtl/odt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : odt_pkg
//  Description : Shared types and default constants for the ODT host port:
//                read/write FSM state encodings, default FIFO depth,
//                synchronizer depth and write timeout.
//  Revision    : 1.0  initial release
// ============================================================================
package odt_pkg;

    // Default receive FIFO depth in bytes (power of two, >= 2)
    localparam int unsigned c_fifo_depth_default  = 4;

    // Default number of synchronizer flops on the peer strobes
    localparam int unsigned c_sync_stages_default = 2;

    // Default number of clk cycles a write may wait for the peer
    localparam logic [15:0] c_timeout_default     = 16'd4096;

    // Read FSM: idle (ready for a byte) or acknowledging a captured byte
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rd_state_e;

    // Write FSM: idle, offering a byte, or waiting for the peer to release
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_DROP = 2'd2
    } wr_state_e;

    // 16-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/odt_host_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : odt_host_port_if
//  Description : ODT peer bus: read strobe/ready, write strobe/ready and the
//                split shared data bus (input, output, output enable).
//                master = the peer side, slave = the host port.
//  Revision    : 1.0  initial release
// ============================================================================
interface odt_host_port_if;

    logic       rstb;   // peer: console-output byte valid on ad
    logic       rrdy;   // host: ready to read / low = acknowledge
    logic       wstb;   // peer: acknowledge of console-input byte
    logic       wrdy;   // host: console-input byte offered on ad
    logic [7:0] ad_i;   // bus value as driven by the peer
    logic [7:0] ad_o;   // bus value driven by the host
    logic       ad_oe;  // host drive enable for ad_o

    modport master (
        output rstb,
        output wstb,
        output ad_i,
        input  rrdy,
        input  wrdy,
        input  ad_o,
        input  ad_oe
    );

    modport slave (
        input  rstb,
        input  wstb,
        input  ad_i,
        output rrdy,
        output wrdy,
        output ad_o,
        output ad_oe
    );

endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous byte FIFO with power-of-two depth, head
//                presented on o_dout, full/empty flags and occupancy count.
//                A pop on a full FIFO frees the slot for a push on the
//                same edge.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [7:0]               i_din,
    input  wire logic                     i_pop,
    output logic      [7:0]               o_dout,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned      c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_full_cnt = (c_aw + 1)'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;

    logic            w_do_pop;
    logic            w_do_push;

    // Pop only real data; push when there is room or a pop frees a slot
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_full_cnt) || w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage array; contents need no reset since occupancy gates them
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_full_cnt);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/odt_host_port.sv
`default_nettype none
// ============================================================================
//  Module      : odt_host_port
//  Description : Host side of the ODT console port. A read FSM captures
//                peer bytes into a receive FIFO exposed as a valid/ready
//                stream; a write FSM offers stream bytes to the peer with a
//                bounded wait. Peer strobes are synchronized before use.
//  Revision    : 1.0  initial release
// ============================================================================
module odt_host_port
    import odt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = c_fifo_depth_default,
    parameter int unsigned SYNC_STAGES = c_sync_stages_default,
    parameter logic [15:0] TIMEOUT     = c_timeout_default
) (
    input  wire logic        clk,
    input  wire logic        rst,
    odt_host_port_if.slave   bus,
    output logic      [7:0]  rx_data,
    output logic             rx_valid,
    input  wire logic        rx_ready,
    input  wire logic [7:0]  tx_data,
    input  wire logic        tx_valid,
    output logic             tx_ready,
    output logic             timeout_err
);

    localparam int unsigned c_cnt_w    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] c_tmo_last = TIMEOUT - 16'd1;

    // ------------------------------------------------------------------
    // Strobe synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_rstb_sync;
    logic [SYNC_STAGES-1:0] r_wstb_sync;
    logic                   w_rstb_s;
    logic                   w_wstb_s;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            // Single flop per strobe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rstb_sync <= '0;
                    r_wstb_sync <= '0;
                end else begin
                    r_rstb_sync <= bus.rstb;
                    r_wstb_sync <= bus.wstb;
                end
            end
        end else begin : g_sync_chain
            // Shift each strobe through a flop chain, oldest bit at the top
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rstb_sync <= '0;
                    r_wstb_sync <= '0;
                end else begin
                    r_rstb_sync <= {r_rstb_sync[SYNC_STAGES-2:0], bus.rstb};
                    r_wstb_sync <= {r_wstb_sync[SYNC_STAGES-2:0], bus.wstb};
                end
            end
        end
    endgenerate

    assign w_rstb_s = r_rstb_sync[SYNC_STAGES-1];
    assign w_wstb_s = r_wstb_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic               w_fifo_room;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (bus.ad_i),
        .i_pop   (w_pop),
        .o_dout  (rx_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign rx_valid    = !w_fifo_empty;
    assign w_pop       = rx_ready && (w_fifo_count != '0);
    // A pop on the same edge frees a slot for the incoming byte
    assign w_fifo_room = !w_fifo_full || w_pop;

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    rd_state_e r_rd_state;

    // Capture exactly once per strobe; a full FIFO stalls the peer in idle
    assign w_push = (r_rd_state == R_IDLE) && w_rstb_s && w_fifo_room;

    // Read state transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_push) begin
                        r_rd_state <= R_ACK;
                    end
                end
                R_ACK: begin
                    if (!w_rstb_s) begin
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign bus.rrdy = (r_rd_state == R_IDLE);

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    wr_state_e   r_wr_state;
    logic [7:0]  r_ad_o;
    logic [15:0] r_tmo_cnt;
    logic        r_timeout_err;
    logic        w_tx_ready;

    // New writes only when the bus is quiet in both directions
    assign w_tx_ready = !rst
                     && (r_wr_state == W_IDLE)
                     && !w_rstb_s
                     && !w_wstb_s
                     && (r_rd_state == R_IDLE);

    // Write state transitions, data latch and bounded wait for the peer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state    <= W_IDLE;
            r_ad_o        <= 8'h00;
            r_tmo_cnt     <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_wr_state)
                W_IDLE: begin
                    if (tx_valid && w_tx_ready) begin
                        r_ad_o     <= tx_data;
                        r_tmo_cnt  <= 16'd0;
                        r_wr_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (w_wstb_s) begin
                        r_wr_state <= W_DROP;
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        r_wr_state    <= W_IDLE;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tmo_cnt <= sat_inc16(r_tmo_cnt);
                    end
                end
                W_DROP: begin
                    if (!w_wstb_s) begin
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign tx_ready    = w_tx_ready;
    assign timeout_err = r_timeout_err;
    assign bus.wrdy    = (r_wr_state == W_REQ);
    assign bus.ad_o    = r_ad_o;
    // Raw rstb gates the driver so the host never fights the peer on ad
    assign bus.ad_oe   = ((r_wr_state == W_REQ) || (r_wr_state == W_DROP))
                      && !bus.rstb;

endmodule
`default_nettype wire

// File: doc/odt_host_port.md
ODT_HOST_PORT -- requirements
Module: odt_host_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO depth in bytes (power of two, at least 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth applied to rstb and wstb.
REQ-003 SHALL have parameter TIMEOUT, default 16'd4096, meaning the clk cycles allowed in W_REQ before the write is abandoned.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port rstb, input, 1 bit: peer strobe meaning a console-output byte is valid on the ad bus (asynchronous).
REQ-007 SHALL have port rrdy, output, 1 bit: high = host ready to read; low = acknowledge of the byte.
REQ-008 SHALL have port wstb, input, 1 bit: peer acknowledge of a console-input byte (asynchronous).
REQ-009 SHALL have port wrdy, output, 1 bit: high = console-input byte offered on ad.
REQ-010 SHALL have ports ad_i (input, 8 bits), ad_o (output, 8 bits) and ad_oe (output, 1 bit): the split shared ODT data bus; the tristate is resolved at top level.
REQ-011 SHALL have ports rx_data (output, 8 bits), rx_valid (output, 1 bit) and rx_ready (input, 1 bit): valid/ready stream of bytes from the CPU.
REQ-012 SHALL have ports tx_data (input, 8 bits), tx_valid (input, 1 bit) and tx_ready (output, 1 bit): valid/ready stream of bytes to the CPU.
REQ-013 SHALL have port timeout_err, output, 1 bit: one-cycle pulse on a write abandon.

Function
REQ-014 SHALL pass rstb and wstb through SYNC_STAGES flops to form rstb_s and wstb_s; the FSMs use only these synchronized signals.
REQ-015 SHALL implement the read FSM with two states:
- R_IDLE: rrdy=1.
- R_ACK: rrdy=0.
REQ-016 SHALL take R_IDLE->R_ACK when rstb_s=1 and the FIFO is not full, pushing ad_i into the FIFO on that same edge.
REQ-017 SHALL hold R_IDLE with rrdy=1 while the FIFO is full and rstb_s=1, so the peer is stalled and no byte is lost.
REQ-018 SHALL take R_ACK->R_IDLE on the first cycle with rstb_s=0; exactly one push occurs per rstb assertion.
REQ-019 SHALL present the FIFO head on rx_data with rx_valid = not empty; a pop occurs on rx_valid & rx_ready.
REQ-020 SHALL, on a simultaneous push and pop when full, pop first so the push succeeds, and count stays unchanged.
REQ-021 SHALL implement the write FSM states W_IDLE, W_REQ and W_DROP.
REQ-022 SHALL assert tx_ready=1 in W_IDLE only when rstb_s=0, wstb_s=0 and the read FSM is in R_IDLE.
REQ-023 SHALL, on tx_valid & tx_ready, latch tx_data into ad_o and go to W_REQ.
REQ-024 SHALL in W_REQ drive ad_oe=1 and wrdy=1, and clear the timeout counter on entry.
REQ-025 SHALL take W_REQ->W_DROP when wstb_s=1.
REQ-026 SHALL take W_REQ->W_IDLE with a timeout_err pulse when the counter reaches TIMEOUT-1; the counter saturates and does not wrap.
REQ-027 SHALL in W_DROP drive wrdy=0 and ad_oe=1, holding ad_o stable until wstb_s=0, then go to W_IDLE with ad_oe=0.
REQ-028 SHALL gate ad_oe combinationally with ~rstb, so the bus is never driven while the peer drives it.
REQ-029 SHALL return ad_oe to 0 no later than the cycle after leaving W_DROP.
REQ-030 SHALL start no new write while rstb_s=1; a pending tx_valid waits with tx_ready=0.

Reset
REQ-031 SHALL, while rst=1, force the following outputs immediately:
- rrdy=1, wrdy=0, ad_oe=0, ad_o=0.
- rx_valid=0, tx_ready=0, timeout_err=0.
REQ-032 SHALL, while rst=1, force FSMs to R_IDLE and W_IDLE, empty the FIFO, clear the synchronizers and zero the timeout counter.
REQ-033 SHALL abandon any transfer in progress when reset is asserted mid-handshake, with no push and no timeout_err.

Structure
REQ-034 SHALL define the read and write state enums and the default TIMEOUT and FIFO_DEPTH constants in shared package odt_pkg.
REQ-035 SHALL implement the receive buffer as one sub-module, byte_fifo (synchronous, parameterized depth, full/empty/count).
REQ-036 SHALL contain both FSMs and the synchronizers in odt_host_port itself.

Verification
REQ-037 SHALL cover a single read: rstb=1 with ad_i=8'h41 -> rrdy low within 4 cycles; rstb=0 -> rrdy=1; rx_data=8'h41 with rx_valid=1.
REQ-038 SHALL cover a full FIFO: 5 reads 8'h30..8'h34 with rx_ready=0 -> 4 bytes accepted, 5th stalled with rrdy=1; one pop -> 8'h34 accepted; order is 30,31,32,33,34.
REQ-039 SHALL cover a single write: tx_data=8'h0D -> ad_oe=1, ad_o=8'h0D, wrdy=1; wstb=1 -> wrdy=0 with ad held; wstb=0 -> ad_oe=0.
REQ-040 SHALL cover a timeout: tx_valid with wstb held 0 -> timeout_err pulse after 4096 cycles, wrdy=0, ad_oe=0, tx_ready=1.
REQ-041 SHALL cover a collision: rstb=1 while tx_valid=1 -> tx_ready=0 and ad_oe=0 until the read completes, then the write proceeds.
REQ-042 SHALL cover mid-handshake reset: rst pulse in R_ACK and in W_REQ -> rrdy=1, wrdy=0, ad_oe=0, FIFO empty.
